// File: rtl/poly_mult_coeff_pipe.sv
// Fully pipelined Montgomery coefficient multiplier: 3-stage b*R2 pre-scale pass, 3-stage m*a pass.
// Optional sticky out-of-range operand flag (op_err) when POLY_MULT_OPERAND_CHECK_EN is defined.
module poly_mult_coeff_pipe #(
   parameter int unsigned W     = 16,
   parameter int unsigned Q     = 12289,
   parameter int unsigned RLOG  = 18,
   parameter int unsigned QINV  = 12287,
   parameter int unsigned R2    = 3186,
   parameter int unsigned TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             precomp,
   input  logic [W-1:0]     doa,
   input  logic [W-1:0]     dob,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     dout,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_last,
   output logic             busy
`ifdef POLY_MULT_OPERAND_CHECK_EN
   ,
   output logic             op_err
`endif
);

   localparam int unsigned PW = 2 * W;
   localparam int unsigned SW = RLOG + W + 1;
   localparam int unsigned NS = 6;
   localparam logic [RLOG-1:0] QINV_L = RLOG'(QINV);

   // Montgomery reduction up to (but excluding) the final conditional subtract.
   function automatic logic [W:0] mr_s(input logic [PW-1:0] x);
      logic [RLOG-1:0] u;
      logic [SW-1:0]   sum;
      u   = RLOG'(x[RLOG-1:0] * QINV_L);
      sum = SW'(x) + SW'(u) * SW'(Q);
      return sum[SW-1:RLOG];
   endfunction

   function automatic logic [W-1:0] csub(input logic [W:0] s);
      return (s >= (W+1)'(Q)) ? W'(s - (W+1)'(Q)) : W'(s);
   endfunction

   logic                 adv;
   logic [NS-1:0]        v_q, v_d;
   logic [NS-1:0]        last_q, last_d;
   logic [TAG_W-1:0]     tag_q [NS];
   logic [TAG_W-1:0]     tag_d [NS];
   logic [W-1:0]         a_q [3];
   logic [W-1:0]         a_d [3];
   logic [1:0]           pc_q, pc_d;
   logic [PW-1:0]        p1_q, p1_d, p4_q, p4_d;
   logic [W:0]           s2_q, s2_d, s5_q, s5_d;
   logic [W-1:0]         m3_q, m3_d, dout_q, dout_d;

   assign adv = ~v_q[NS-1] | out_ready;

   // Every stage either shifts as a whole or holds as a whole.
   always_comb begin
      v_d    = v_q;
      last_d = last_q;
      tag_d  = tag_q;
      a_d    = a_q;
      pc_d   = pc_q;
      p1_d   = p1_q;
      s2_d   = s2_q;
      m3_d   = m3_q;
      p4_d   = p4_q;
      s5_d   = s5_q;
      dout_d = dout_q;
      if (adv) begin
         v_d    = {v_q[NS-2:0], in_valid};
         last_d = {last_q[NS-2:0], in_last};
         tag_d[0] = in_tag;
         for (int i = 1; i < NS; i++) tag_d[i] = tag_q[i-1];
         a_d[0] = doa;
         a_d[1] = a_q[0];
         a_d[2] = a_q[1];
         pc_d   = {pc_q[0], precomp};
         p1_d   = precomp ? PW'(dob) : PW'(dob) * PW'(R2);
         s2_d   = pc_q[0] ? (W+1)'(p1_q[W-1:0]) : mr_s(p1_q);
         m3_d   = pc_q[1] ? s2_q[W-1:0] : csub(s2_q);
         p4_d   = PW'(m3_q) * PW'(a_q[2]);
         s5_d   = mr_s(p4_q);
         dout_d = csub(s5_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q    <= '0;
         last_q <= '0;
         tag_q  <= '{default: '0};
         a_q    <= '{default: '0};
         pc_q   <= '0;
         p1_q   <= '0;
         s2_q   <= '0;
         m3_q   <= '0;
         p4_q   <= '0;
         s5_q   <= '0;
         dout_q <= '0;
      end else begin
         v_q    <= v_d;
         last_q <= last_d;
         tag_q  <= tag_d;
         a_q    <= a_d;
         pc_q   <= pc_d;
         p1_q   <= p1_d;
         s2_q   <= s2_d;
         m3_q   <= m3_d;
         p4_q   <= p4_d;
         s5_q   <= s5_d;
         dout_q <= dout_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = v_q[NS-1];
   assign dout      = dout_q;
   assign out_tag   = tag_q[NS-1];
   assign out_last  = last_q[NS-1];
   assign busy      = |v_q;

`ifdef POLY_MULT_OPERAND_CHECK_EN
   logic op_err_q, op_err_d;

   always_comb begin
      op_err_d = op_err_q | (in_valid & adv & ((doa >= W'(Q)) | (dob >= W'(Q))));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) op_err_q <= 1'b0;
      else     op_err_q <= op_err_d;
   end

   assign op_err = op_err_q;
`endif

endmodule

// File: tb/tb_poly_mult_coeff_pipe.sv
// Randomised self-checking bench for poly_mult_coeff_pipe against a plain modular-arithmetic model.
module tb_poly_mult_coeff_pipe;

   localparam int unsigned W = 16;
   localparam int unsigned TAG_W = 8;
   localparam longint Q = 12289;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             precomp;
   logic [W-1:0]     doa;
   logic [W-1:0]     dob;
   logic [TAG_W-1:0] in_tag;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     dout;
   logic [TAG_W-1:0] out_tag;
   logic             out_last;
   logic             busy;
`ifdef POLY_MULT_OPERAND_CHECK_EN
   logic             op_err;
`endif

   poly_mult_coeff_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .precomp(precomp),
      .doa(doa), .dob(dob), .in_tag(in_tag), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .dout(dout), .out_tag(out_tag), .out_last(out_last), .busy(busy)
`ifdef POLY_MULT_OPERAND_CHECK_EN
      , .op_err(op_err)
`endif
   );

   typedef struct {
      int     d;
      int     tag;
      bit     last;
      bit     dc;
      longint acc;
   } exp_t;

   exp_t   sb[$];
   int     ncmp = 0;
   int     nerr = 0;
   longint cyc = 0;
   longint rinv = 0;
   bit     lat_chk = 0;
   bit     rdy_rand = 0;
   bit     hold_v = 0;
   int     h_dout, h_tag, h_last;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
   end

   function automatic void chk(string nm, longint got, longint exp);
      ncmp++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", nm, got, exp);
      end
   endfunction

   function automatic int exp_val(int a, int b, bit pc);
      longint p;
      p = (longint'(a) * longint'(b)) % Q;
      if (pc) p = (p * rinv) % Q;
      return int'(p);
   endfunction

   // Scoreboard: record accepted inputs, check consumed outputs, stall stability and in_ready.
   always @(negedge clk) begin
      if (rst) begin
         hold_v = 0;
      end else begin
         if (hold_v) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_dout", longint'(dout), h_dout);
            chk("hold_tag", longint'(out_tag), h_tag);
            chk("hold_last", longint'(out_last), h_last);
         end
         chk("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
         if (in_valid && in_ready) begin
            exp_t e;
            e.dc   = (longint'(doa) >= Q) || (longint'(dob) >= Q);
            e.d    = e.dc ? 0 : exp_val(int'(doa), int'(dob), precomp);
            e.tag  = int'(in_tag);
            e.last = in_last;
            e.acc  = cyc;
            sb.push_back(e);
         end
         if (out_valid && out_ready) begin
            chk("expected_output", longint'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               if (!e.dc) chk("dout", longint'(dout), e.d);
               chk("out_tag", longint'(out_tag), e.tag);
               chk("out_last", longint'(out_last), longint'(e.last));
               if (lat_chk) chk("latency", cyc - e.acc, 6);
            end
         end
         hold_v = out_valid && !out_ready;
         h_dout = int'(dout);
         h_tag  = int'(out_tag);
         h_last = int'(out_last);
      end
   end

   task automatic send(input int a, input int b, input bit pc, input int tag, input bit last);
      int n;
      n        = 0;
      doa      = 16'(a);
      dob      = 16'(b);
      precomp  = pc;
      in_tag   = 8'(tag);
      in_last  = last;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", longint'(sb.size() == 0 && !busy), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      sb.delete();
      #1;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_dout", longint'(dout), 0);
      chk("rst_out_tag", longint'(out_tag), 0);
      chk("rst_out_last", longint'(out_last), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_in_ready", longint'(in_ready), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      longint rmodq;
      rst = 1'b1; in_valid = 1'b0; precomp = 1'b0; doa = '0; dob = '0;
      in_tag = '0; in_last = 1'b0; out_ready = 1'b1;
      rmodq = (longint'(1) << 18) % Q;
      for (longint r = 1; r < Q; r++) if ((r * rmodq) % Q == 1) rinv = r;

      @(posedge clk);
      #1;
      reset_pulse();
`ifdef POLY_MULT_OPERAND_CHECK_EN
      chk("op_err_reset", longint'(op_err), 0);
`endif

      // Basic back-to-back products, fixed latency.
      lat_chk = 1;
      send(2, 3, 0, 1, 0);
      send(12288, 12288, 0, 2, 0);
      send(0, 777, 0, 3, 0);
      send(1, 1, 0, 4, 1);
      drain();

      // Mixed modes back to back.
      send(4075, 5, 1, 10, 0);
      send(2, 3, 0, 11, 0);
      send(4075, 5, 1, 12, 0);
      send($urandom_range(0, 12288), $urandom_range(0, 12288), 1, 13, 1);
      drain();
      lat_chk = 0;

      // Backpressure.
      rdy_rand = 1;
      for (int i = 0; i < 10; i++)
         send($urandom_range(0, 12288), $urandom_range(0, 12288), 1'($urandom_range(0, 1)), i, i == 9);
      rdy_rand = 0;
      out_ready = 1'b1;
      drain();

      // Sideband sweep with random operands and stalls.
      rdy_rand = 1;
      for (int i = 0; i < 256; i++)
         send($urandom_range(0, 12288), $urandom_range(0, 12288), 1'($urandom_range(0, 1)), i, i == 255);
      rdy_rand = 0;
      out_ready = 1'b1;
      drain();

      // Random traffic with input gaps.
      rdy_rand = 1;
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send($urandom_range(0, 12288), $urandom_range(0, 12288), 1'($urandom_range(0, 1)),
              $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      end
      rdy_rand = 0;
      out_ready = 1'b1;
      drain();

      // Reset with four items in flight, then a clean restart.
      lat_chk = 1;
      send(5, 6, 0, 1, 0);
      send(7, 8, 0, 2, 0);
      send(9, 10, 0, 3, 0);
      send(11, 12, 0, 4, 1);
      chk("busy_in_flight", longint'(busy), 1);
      reset_pulse();
      send(3, 4, 0, 77, 1);
      drain();
      lat_chk = 0;

`ifdef POLY_MULT_OPERAND_CHECK_EN
      chk("op_err_clean", longint'(op_err), 0);
      send(12289, 1, 0, 5, 0);
      chk("op_err_set", longint'(op_err), 1);
      send(2, 3, 0, 6, 0);
      send(4075, 5, 1, 7, 1);
      drain();
      chk("op_err_sticky", longint'(op_err), 1);
      reset_pulse();
      chk("op_err_cleared", longint'(op_err), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
